// File: rtl/led_burst_sequencer_pkg.sv
// Shared types and frame helpers for the LED burst sequencer.
// Pattern math is written for up to 16 LEDs.
package led_seq_pkg;

    typedef enum logic [1:0] {
        BURST,
        IMPLODE,
        FLASH,
        SWEEP
    } seq_mode_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic int frames_for_mode(seq_mode_t mode, int led_w);
        int n;
        case (mode)
            BURST:   n = led_w / 2 + 3;
            IMPLODE: n = led_w / 2 + 3;
            FLASH:   n = 6;
            default: n = led_w + 1;
        endcase
        return n;
    endfunction

    // Ring k of the burst: LEDs whose distance from the centre
    // lies in [max(0,k-2), min(k,H-1)].
    function automatic logic [15:0] burst_frame(int k, int led_w);
        logic [15:0] r;
        int h;
        int lo;
        int hi;
        int d;
        h = led_w / 2;
        lo = (k > 2) ? k - 2 : 0;
        hi = (k < h - 1) ? k : h - 1;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            d = (i >= h) ? i - h : h - 1 - i;
            if (i < led_w && d >= lo && d <= hi) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_burst_sequencer_if.sv
// Control/status bundle between the game FSM and the sequencer.
// The game side drives start/mode/reps, the sequencer drives led/busy/done.
interface led_burst_sequencer_if #(
    parameter int LED_W = 10,
    parameter int REP_W = 4
);
    import led_seq_pkg::*;

    logic             start;
    seq_mode_t        mode;
    logic [REP_W-1:0] reps;
    logic [LED_W-1:0] led;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output mode,
        output reps,
        input  led,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  mode,
        input  reps,
        output led,
        output busy,
        output done
    );

endinterface

// File: rtl/led_burst_sequencer_prescaler.sv
// Frame prescaler: tick is high on the last of every DIV cycles.
// clr forces the count back to zero so a new frame gets its full length.
module led_tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_burst_sequencer.sv
// LED animation engine: burst/implode/flash/sweep, repeated reps+1 times.
// Define LED_SEQ_RETRIGGER_EN to let start restart a running sequence.
module led_burst_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_W    = 10,
    parameter int TICK_DIV = 25_000_000,
    parameter int REP_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    led_burst_sequencer_if.slave bus
);

    localparam int FW = $clog2(LED_W + 2);

    state_t           state;
    seq_mode_t        mode_q;
    logic [REP_W-1:0] reps_q;
    logic [REP_W-1:0] rep;
    logic [FW-1:0]    frame;
    logic [FW-1:0]    last_idx;
    logic [LED_W-1:0] led_q;
    logic             busy_q;
    logic             done_q;

    logic             tick;
    logic             accept;
    logic             last_frame;
    logic             advance;
    logic             clr;
    seq_mode_t        pat_mode;
    logic [FW-1:0]    pat_frame;
    logic [LED_W-1:0] pat;

    function automatic logic [LED_W-1:0] frame_pattern(
        seq_mode_t m,
        logic [FW-1:0] f
    );
        logic [15:0] w;
        int h;
        int fi;
        h = LED_W / 2;
        fi = int'(f);
        w = '0;
        case (m)
            BURST: begin
                if (fi <= h + 1) w = burst_frame(fi, LED_W);
            end
            IMPLODE: begin
                if (fi <= h + 1) w = burst_frame(h + 1 - fi, LED_W);
            end
            FLASH: begin
                if (fi < 6 && (fi % 2) == 0) w = 16'hFFFF;
            end
            default: begin
                if (fi < LED_W) w = 16'(1) << fi;
            end
        endcase
        return w[LED_W-1:0];
    endfunction

`ifdef LED_SEQ_RETRIGGER_EN
    assign accept = bus.start;
`else
    assign accept = bus.start && (state == IDLE);
`endif

    assign last_idx   = FW'(frames_for_mode(mode_q, LED_W) - 1);
    assign last_frame = (frame == last_idx);
    assign advance    = (state == RUN) && tick;
    assign clr        = accept || (state == IDLE);

    led_tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    // Pattern for whichever frame is about to be loaded into led_q.
    always_comb begin
        pat_mode  = accept ? bus.mode : mode_q;
        pat_frame = (accept || last_frame) ? '0 : frame + FW'(1);
        pat       = frame_pattern(pat_mode, pat_frame);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode_q <= BURST;
            reps_q <= '0;
            rep    <= '0;
            frame  <= '0;
            led_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state  <= RUN;
                mode_q <= bus.mode;
                reps_q <= bus.reps;
                rep    <= '0;
                frame  <= '0;
                led_q  <= pat;
                busy_q <= 1'b1;
            end else if (advance) begin
                if (!last_frame) begin
                    frame <= frame + FW'(1);
                    led_q <= pat;
                end else if (rep < reps_q) begin
                    rep   <= rep + REP_W'(1);
                    frame <= '0;
                    led_q <= pat;
                end else begin
                    state  <= IDLE;
                    frame  <= '0;
                    led_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_led_burst_sequencer.sv
// Bench for led_burst_sequencer with LED_W=10, TICK_DIV=4.
// Expected led/busy/done per cycle come from fixed frame tables.
module tb_led_burst_sequencer;
    import led_seq_pkg::*;

    localparam int LW = 10;
    localparam int TD = 4;
    localparam int RW = 4;
`ifdef LED_SEQ_RETRIGGER_EN
    localparam int HOLD = 1;
`else
    localparam int HOLD = 20;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    led_burst_sequencer_if #(.LED_W(LW), .REP_W(RW)) bus ();

    led_burst_sequencer #(
        .LED_W    (LW),
        .TICK_DIV (TD),
        .REP_W    (RW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [LW-1:0] led;
        logic          busy;
        logic          done;
    } exp_t;

    typedef struct {
        int mode;
        int reps;
        int frames;
        int busy_cycles;
        int hold;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[6];
    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic [LW-1:0] burst_tab [0:7] = '{
        10'h030, 10'h078, 10'h0FC, 10'h1CE,
        10'h387, 10'h303, 10'h201, 10'h000
    };
    logic [LW-1:0] implode_tab [0:7] = '{
        10'h201, 10'h303, 10'h387, 10'h1CE,
        10'h0FC, 10'h078, 10'h030, 10'h000
    };

    function automatic logic [LW-1:0] exp_frame(int m, int f);
        logic [LW-1:0] one;
        one = 10'h001;
        case (m)
            0: return burst_tab[f];
            1: return implode_tab[f];
            2: return (f % 2 == 0) ? 10'h3FF : 10'h000;
            default: return (f < LW) ? (one << f) : 10'h000;
        endcase
    endfunction

    task automatic step(
        input bit st, input int m, input int r, input bit rn,
        input logic [LW-1:0] el, input bit eb, input bit ed,
        input string nm
    );
        exp_t e;
        exp_t g;
        logic [1:0] mv;
        mv = m[1:0];
        rst_n = rn;
        bus.start = st;
        bus.mode = seq_mode_t'(mv);
        bus.reps = r[RW-1:0];
        e.led = el;
        e.busy = eb;
        e.done = ed;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        g = exp_q.pop_front();
        checks++;
        if (bus.led === g.led && bus.busy === g.busy &&
            bus.done === g.done) begin
            passed++;
        end else begin
            $display("FAIL %s cyc=%0d got led=%h busy=%b done=%b want led=%h busy=%b done=%b",
                     nm, cyc, bus.led, bus.busy, bus.done,
                     g.led, g.busy, g.done);
        end
    endtask

    task automatic play(
        input int m, input int r, input int frames,
        input int busy_cycles, input int hold, input string nm
    );
        int p;
        p = frames * TD;
        for (int c = 0; c < busy_cycles; c++) begin
            step((c == 0) || (c < hold), m, r, 1'b1,
                 exp_frame(m, (c % p) / TD), 1'b1, 1'b0, nm);
        end
    endtask

    initial begin
        bus.start = 1'b1;
        bus.mode = BURST;
        bus.reps = '0;

        vt[0] = '{0, 0, 8, 32, 1};
        vt[1] = '{3, 1, 11, 88, 1};
        vt[2] = '{2, 0, 6, 24, 1};
        vt[3] = '{0, 0, 8, 32, HOLD};
        vt[4] = '{2, 15, 6, 384, 1};
        vt[5] = '{1, 2, 8, 96, 1};

        repeat (3) step(1'b1, 0, 0, 1'b0, '0, 1'b0, 1'b0, "reset");

        for (int i = 0; i < 6; i++) begin
            play(vt[i].mode, vt[i].reps, vt[i].frames,
                 vt[i].busy_cycles, vt[i].hold, "vec_run");
            step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b1, "vec_done");
            step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b0, "vec_idle");
        end

        play(2, 0, 6, 24, 1, "flash");
        step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b1, "flash_done");
        play(1, 0, 8, 32, 1, "b2b_implode");
        step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b1, "b2b_done");
        step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b0, "b2b_idle");

`ifdef LED_SEQ_RETRIGGER_EN
        for (int c = 0; c < 10; c++) begin
            step(c == 0, 0, 0, 1'b1, exp_frame(0, c / TD),
                 1'b1, 1'b0, "retrig_burst");
        end
        for (int c = 10; c < 54; c++) begin
            step(c == 10, 3, 0, 1'b1, exp_frame(3, (c - 10) / TD),
                 1'b1, 1'b0, "retrig_sweep");
        end
        step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b1, "retrig_done");
`else
        for (int c = 0; c < 32; c++) begin
            step((c == 0) || (c == 10), (c == 10) ? 3 : 0, 0, 1'b1,
                 exp_frame(0, c / TD), 1'b1, 1'b0, "ignore_start");
        end
        step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b1, "ignore_done");
`endif
        step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b0, "t5_idle");

        for (int c = 0; c < 13; c++) begin
            step(c == 0, 0, 0, 1'b1, exp_frame(0, c / TD),
                 1'b1, 1'b0, "pre_reset");
        end
        step(1'b0, 0, 0, 1'b0, '0, 1'b0, 1'b0, "mid_reset");
        for (int c = 14; c < 50; c++) begin
            step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b0, "post_reset");
        end
        play(0, 0, 8, 32, 1, "fresh_burst");
        step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b1, "fresh_done");
        step(1'b0, 0, 0, 1'b1, '0, 1'b0, 1'b0, "fresh_idle");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/led_burst_sequencer.md
Name: led_burst_sequencer

Overview:
Parametrised LED animation engine for torpedo/hit/miss feedback on the board LED bank. It generalises the fixed 10-LED, 8-state sparkler: LED count, frame period and repeat count are configurable, and four animation modes are selectable. The prescaler is internal, so the block runs on the 100 MHz system clock and needs no external divider. It sits between game-control FSM strobes and the `led` outputs.

Parameters:
LED_W, 10, number of LEDs; even, 4..16.
TICK_DIV, 25_000_000, clk cycles per animation frame; must be >= 1 (benches use 4).
REP_W, 4, width of the repeat-count input.

Ports:
clk  in  1  system clock, all logic on posedge.
rst_n  in  1  synchronous active-low reset.
start  in  1  request to play an animation; sampled every cycle.
mode  in  2  0=burst, 1=implode, 2=flash, 3=sweep; latched when start is accepted.
reps  in  REP_W  extra repetitions; latched when start is accepted; sequence plays reps+1 times.
led  out  LED_W  registered LED pattern.
busy  out  1  high while a sequence is playing.
done  out  1  one-cycle pulse when the last frame of the last repetition expires.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, led=0, busy=0, done=0, prescaler=0, frame=0, rep=0. Reset wins over start. A reset mid-sequence blanks `led` at the next edge.
- States:
  - IDLE: led=0, busy=0.
  - RUN: busy=1.
- Start accept: in IDLE, start=1 at edge N. At that edge, mode and reps are latched, frame=0, rep=0, prescaler cleared. From edge N: led=frame0, busy=1. Latency is one edge.
- Frame timing: each frame is held exactly TICK_DIV cycles. The prescaler counts 0..TICK_DIV-1; on terminal count the frame advances.
- End of a repetition (last frame expires):
  - If rep < reps_latched: rep++, frame=0.
  - Otherwise: IDLE, led=0, busy=0, done=1 for exactly that one cycle.
- Start in the done cycle (state already IDLE) is accepted. Back-to-back sequences have no gap.
- Start while busy is ignored (level or pulse).
- Frame patterns (H=LED_W/2). Distance of bit i: d=i-H for i>=H; d=H-1-i for i<H.
  - mode 0 burst: frames k=0..H+1 light bits with max(0,k-2) <= d <= min(k,H-1); then one blank frame. F=H+3 frames.
  - mode 1 implode: burst frames k=H+1..0 in reverse order, then blank. F=H+3.
  - mode 2 flash: 6 frames alternating all-ones / all-zeros, starting all-ones. F=6.
  - mode 3 sweep: frame j (0..LED_W-1) lights only bit j; then blank. F=LED_W+1.
- Widths: frame counter is $clog2(LED_W+2) bits; the prescaler is $clog2(TICK_DIV) bits, minimum 1. reps=all-ones gives 2^REP_W plays with no overflow.

Optional Feature:
LED_SEQ_RETRIGGER_EN
- Defined: start=1 while busy restarts the sequence at that edge. New mode and reps are latched, frame=0, rep=0, prescaler cleared, led=new frame0. No done pulse is emitted for the aborted sequence.
- Undefined: start while busy is ignored, as above.

Decomposition:
- Package led_seq_pkg holds:
  - typedef enum logic [1:0] seq_mode_t {BURST, IMPLODE, FLASH, SWEEP}
  - typedef enum logic state_t {IDLE, RUN}
  - function frames_for_mode(mode, LED_W)
  - function burst_frame(k, LED_W)
- One sub-module: led_tick_prescaler (params DIV; ports clk, rst_n, clr, tick). The pattern generator stays combinational inside the top, feeding the led register.

Test Plan (LED_W=10, TICK_DIV=4):
1. Hold rst_n=0 for 3 cycles with start=1 -> led=0, busy=0, done=0 throughout. First accept happens one edge after rst_n rises.
2. mode=0, reps=0, 1-cycle start -> led holds each value for 4 cycles: 0x030, 0x078, 0x0FC, 0x1CE, 0x387, 0x303, 0x201, 0x000. done pulses exactly once, 32 cycles after the accept edge; busy falls on the same edge.
3. mode=3, reps=1 -> 0x001, 0x002 ... 0x200, 0x000, played twice. busy is high for 88 cycles. A single done pulse occurs at cycle 88.
4. mode=2, reps=0 -> 0x3FF, 0x000, 0x3FF, 0x000, 0x3FF, 0x000 (4 cycles each); done at 24. Then start asserted in the done cycle with mode=1 -> 0x201 appears on the next edge with no idle gap.
5. mode=0 running; start with mode=3 pulsed at cycle 10 -> without macro, the burst completes unchanged and done is at 32. With LED_SEQ_RETRIGGER_EN, led=0x001 at the next edge, no done at 32, and done at 10+44.
6. rst_n=0 at cycle 13 of a mode-0 run -> led=0, busy=0, done=0 at the next edge. No done pulse follows. A fresh start then replays from 0x030.
